// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg
//   Shared types and helpers for the FIFO stream reader family.
//   - rd_state_e    : reader FSM states
//   - BURST_MAX_DEF : default maximum burst length in words
//   - calc_lw()     : width needed to hold a burst length of 0..burst_max
package fifo_stream_pkg;

  localparam int BURST_MAX_DEF = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_e;

  function automatic int calc_lw(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// stream_skid_buf2
//   Two-entry register buffer for valid/ready streams. Entry 0 is the head.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     flush       : drop all entries (wins over push/pop)
//     push, din   : write din at the tail
//     pop         : remove the head (ignored when empty)
//     count       : number of entries held (0..2)
//     head        : head entry, registered
module stream_skid_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic [1:0]       cnt;
  logic             pop_eff;

  assign pop_eff = pop && (cnt != 2'd0);
  assign count   = cnt;
  assign head    = ent0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop_eff})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else             ent1 <= din;
          if (cnt != 2'd2) cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands
          // behind whatever is still queued so order is preserved.
          if (cnt == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // Upstream credit logic must never push into a full buffer without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_eff && !flush && cnt == 2'd2));

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains a synchronous FIFO (one-cycle registered read latency) and
//   presents a burst of burst_len words as a valid/ready stream.
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     start, burst_len   : begin a burst of 1..BURST_MAX words (IDLE only)
//     abort              : terminate the current burst immediately
//     fifo_empty         : FIFO empty flag
//     fifo_rd_en         : FIFO read enable (combinational)
//     fifo_data          : FIFO read data, valid the cycle after fifo_rd_en
//     m_valid/m_ready    : stream handshake
//     m_data, m_last     : stream word and end-of-burst marker
//     busy               : burst in progress
//     done               : one-cycle pulse after the final word is accepted
//     words_out          : words accepted downstream in the current burst
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a legal start; outputs quiet
//   RUN   | issuing FIFO reads and streaming words until N accepted
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int LW        = calc_lw(BURST_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LW-1:0]    burst_len,
  input  logic             abort,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    words_out
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]    state;
  logic [LW-1:0] n_len;
  logic [LW-1:0] issued;
  logic [LW-1:0] words_cnt;
  logic          inflight;
  logic [1:0]    buf_count;
  logic          run;
  logic          pop;
  logic          start_ok;
  logic          last_hs;
  logic [2:0]    occ_now;
  logic [2:0]    occ_next;

  assign run  = (state == ST_RUN);
  assign pop  = m_valid && m_ready;
  assign busy = run;

  assign start_ok = (state == ST_IDLE) && start &&
                    (burst_len != '0) && (burst_len <= LW'(BURST_MAX));

  assign last_hs = pop && (words_cnt == n_len - LW'(1));

  // Credit check counts the word already in flight, so the buffer can
  // absorb everything requested even if downstream stalls right now.
  assign occ_now    = {1'b0, buf_count} + {2'b00, inflight};
  assign occ_next   = occ_now - {2'b00, pop};
  assign fifo_rd_en = run && !fifo_empty && (issued < n_len) && (occ_next < 3'd2);

  assign m_valid   = (buf_count != 2'd0);
  assign m_last    = m_valid && (words_cnt == n_len - LW'(1));
  assign words_out = words_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      n_len     <= '0;
      issued    <= '0;
      words_cnt <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state     <= ST_RUN;
            n_len     <= burst_len;
            issued    <= '0;
            words_cnt <= '0;
          end
        end
        ST_RUN: begin
          // Abort drops any read still in flight; that FIFO word is lost.
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            inflight <= fifo_rd_en;
            if (fifo_rd_en) issued    <= issued + LW'(1);
            if (pop)        words_cnt <= words_cnt + LW'(1);
            if (last_hs) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  stream_skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (run && abort),
    .push  (inflight),
    .din   (fifo_data),
    .pop   (pop),
    .count (buf_count),
    .head  (m_data)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: directed table and sequences plus a
// randomized run, all compared against a queue-based reference model.
module tb_fifo_stream_reader;
  import fifo_stream_pkg::*;

  localparam int WIDTH = 8;
  localparam int BMAX  = 64;
  localparam int LW    = calc_lw(BMAX);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LW-1:0]    burst_len;
  logic             abort;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic             done;
  logic [LW-1:0]    words_out;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(WIDTH), .BURST_MAX(BMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .words_out  (words_out)
  );

  int tests = 0;
  int fails = 0;

  // FIFO environment contents
  logic [7:0] fq[$];

  // reference model
  bit         mactive;
  int         mN, missued, macc;
  logic [7:0] mbuf[$];
  bit         minfl;
  logic [7:0] minfl_word;
  bit         mdone;
  bit         chk_en;

  // sampled outputs and observation counters
  logic       s_rd, s_valid, s_last, s_busy, s_done;
  logic [7:0] s_data;
  int         rd_cnt, hs_cnt;
  logic [8:0] got[$];

  typedef struct {
    int start; int len; int mr; int ab;
    int rd; int valid; int data; int last; int busy; int done;
  } vec_t;
  vec_t basic[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit pop, input bit rd, input logic [7:0] w);
    bit nd;
    nd = 1'b0;
    if (rst) begin
      mactive = 0; mbuf.delete(); minfl = 0; missued = 0; macc = 0; mN = 0;
    end else if (mactive && abort) begin
      mactive = 0; mbuf.delete(); minfl = 0;
    end else if (mactive) begin
      if (pop) begin
        mbuf.delete(0);
        macc++;
        if (macc == mN) begin mactive = 0; nd = 1'b1; end
      end
      if (minfl) mbuf.push_back(minfl_word);
      if (rd) missued++;
      minfl = rd;
      minfl_word = w;
    end else if (start && burst_len >= 1 && burst_len <= BMAX) begin
      mactive = 1; mN = int'(burst_len); missued = 0; macc = 0;
    end
    mdone = nd;
  endtask

  // One clock cycle: inputs already driven; sample mid-cycle, advance edge.
  task automatic cycle();
    int         occ;
    bit         pop, exp_rd, exp_valid;
    logic [7:0] w;
    fifo_empty = (fq.size() == 0);
    #4;
    exp_valid = (mbuf.size() != 0);
    pop    = exp_valid && m_ready;
    occ    = mbuf.size() + int'(minfl) - int'(pop);
    exp_rd = mactive && (fq.size() != 0) && (missued < mN) && (occ < 2);
    s_rd = fifo_rd_en; s_valid = m_valid; s_last = m_last;
    s_busy = busy; s_done = done; s_data = m_data;
    if (chk_en) begin
      check("rd_en",     fifo_rd_en, exp_rd);
      check("m_valid",   m_valid,    exp_valid);
      check("m_last",    m_last,     exp_valid && (macc == mN - 1));
      check("busy",      busy,       mactive);
      check("done",      done,       mdone);
      check("words_out", words_out,  macc);
      if (exp_valid) check("m_data", m_data, mbuf[0]);
    end
    if (fifo_rd_en === 1'b1) rd_cnt++;
    if (m_valid === 1'b1 && m_ready) begin
      hs_cnt++;
      got.push_back({m_last, m_data});
    end
    @(posedge clk);
    #1;
    w = fifo_data;
    if (s_rd === 1'b1 && fq.size() != 0) begin
      w = fq.pop_front();
      fifo_data = w;
    end
    model_edge(pop, exp_rd, w);
  endtask

  task automatic run_until_idle(input int bound, input string name);
    int n;
    n = 0;
    while (mactive && n < bound) begin
      cycle();
      n++;
    end
    check(name, mactive, 0);
  endtask

  task automatic drive(input bit st, input int len, input bit mr, input bit ab);
    start = st; burst_len = LW'(len); m_ready = mr; abort = ab;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    mactive = 0; mN = 0; missued = 0; macc = 0; minfl = 0; mdone = 0;
    chk_en = 0; rd_cnt = 0; hs_cnt = 0;
    fifo_data = 8'h00;
    rst = 1'b1;
    drive(1'b1, 4, 1'($urandom), 1'($urandom));
    fq.push_back(8'h5A);

    // 1. reset with random inputs, start asserted during reset
    cycle();
    chk_en = 1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4, 1'($urandom), 1'($urandom));
      cycle();
    end
    check("rst_m_data", s_data, 8'h00);
    rst = 1'b0;
    drive(1'b0, 0, 1'b1, 1'b0);
    fq.delete();
    cycle();
    check("rst_busy", s_busy, 0);

    // 2. basic burst, table-driven
    basic[0] = '{start:1, len:4, mr:1, ab:0, rd:0, valid:0, data:0,     last:0, busy:0, done:0};
    basic[1] = '{start:0, len:0, mr:1, ab:0, rd:1, valid:0, data:0,     last:0, busy:1, done:0};
    basic[2] = '{start:0, len:0, mr:1, ab:0, rd:1, valid:0, data:0,     last:0, busy:1, done:0};
    basic[3] = '{start:0, len:0, mr:1, ab:0, rd:1, valid:1, data:'h11,  last:0, busy:1, done:0};
    basic[4] = '{start:0, len:0, mr:1, ab:0, rd:1, valid:1, data:'h22,  last:0, busy:1, done:0};
    basic[5] = '{start:0, len:0, mr:1, ab:0, rd:0, valid:1, data:'h33,  last:0, busy:1, done:0};
    basic[6] = '{start:0, len:0, mr:1, ab:0, rd:0, valid:1, data:'h44,  last:1, busy:1, done:0};
    basic[7] = '{start:0, len:0, mr:1, ab:0, rd:0, valid:0, data:0,     last:0, busy:0, done:1};
    basic[8] = '{start:0, len:0, mr:1, ab:0, rd:0, valid:0, data:0,     last:0, busy:0, done:0};
    fq = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 9; i++) begin
      drive(basic[i].start[0], basic[i].len, basic[i].mr[0], basic[i].ab[0]);
      cycle();
      check("tbl_rd",    s_rd,    basic[i].rd);
      check("tbl_valid", s_valid, basic[i].valid);
      check("tbl_last",  s_last,  basic[i].last);
      check("tbl_busy",  s_busy,  basic[i].busy);
      check("tbl_done",  s_done,  basic[i].done);
      if (basic[i].valid != 0) check("tbl_data", s_data, basic[i].data);
    end

    // 3. backpressure: stall from cycle 3 for 10 cycles
    fq.delete(); got.delete(); rd_cnt = 0; bad = 0;
    for (int i = 1; i <= 8; i++) fq.push_back(8'(i * 8'h11));
    for (int c = 0; c < 13; c++) begin
      drive(c == 0, 8, c < 3, 1'b0);
      cycle();
      if (c >= 3 && !(s_valid === 1'b1 && s_data === 8'h11)) bad++;
    end
    check("bp_reads", rd_cnt, 2);
    check("bp_hold", bad, 0);
    drive(1'b0, 0, 1'b1, 1'b0);
    run_until_idle(40, "bp_timeout");
    check("bp_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      check("bp_order", got[i], {(i == 7), 8'((i + 1) * 8'h11)});

    // 4. FIFO underrun mid-burst
    cycle();
    fq.delete(); got.delete(); rd_cnt = 0;
    fq = '{8'hA1, 8'hA2};
    for (int c = 0; c < 9; c++) begin
      drive(c == 0, 5, 1'b1, 1'b0);
      cycle();
    end
    check("ur_reads", rd_cnt, 2);
    check("ur_rd_low", s_rd, 0);
    check("ur_busy", s_busy, 1);
    fq.push_back(8'hA3); fq.push_back(8'hA4); fq.push_back(8'hA5);
    run_until_idle(30, "ur_timeout");
    check("ur_count", got.size(), 5);
    if (got.size() == 5) begin
      check("ur_last_word", got[4], {1'b1, 8'hA5});
      check("ur_not_last",  got[3][8], 0);
    end

    // 5. abort after the 2nd handshake, restart next cycle
    cycle();
    fq.delete(); got.delete(); hs_cnt = 0;
    fq = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};
    drive(1'b1, 6, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 0, 1'b1, 1'b0);
    for (int n = 0; n < 20 && hs_cnt < 2; n++) cycle();
    check("ab_hs_reached", hs_cnt >= 2, 1);
    drive(1'b0, 0, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 1, 1'b1, 1'b0);
    cycle();
    check("ab_valid", s_valid, 0);
    check("ab_busy",  s_busy,  0);
    check("ab_done",  s_done,  0);
    drive(1'b0, 0, 1'b1, 1'b0);
    cycle();
    check("ab_restart", s_busy, 1);
    check("ab_done2",   s_done, 0);
    run_until_idle(20, "ab_timeout");
    check("ab_new_word", got[got.size() - 1], {1'b1, 8'hB6});

    // 6. illegal start and start during RUN
    cycle();
    fq.delete(); got.delete(); rd_cnt = 0;
    fq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 0, 1'b1, 1'b0);
      cycle();
    end
    check("zl_reads", rd_cnt, 0);
    check("zl_busy", s_busy, 0);
    drive(1'b1, 3, 1'b1, 1'b0); cycle();
    drive(1'b0, 0, 1'b1, 1'b0); cycle();
    drive(1'b1, 5, 1'b1, 1'b0); cycle();
    drive(1'b0, 0, 1'b1, 1'b0);
    run_until_idle(20, "rs_timeout");
    check("rs_count", got.size(), 3);
    if (got.size() == 3) check("rs_last", got[2], {1'b1, 8'hC3});
    cycle();
    fq.delete();

    // 7. randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, 7) == 0);
      burst_len = LW'($urandom_range(0, 70));
      abort     = ($urandom_range(0, 99) == 0);
      m_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && fq.size() < 12) fq.push_back(8'($urandom));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
